// File: rtl/debounce_ctrl.sv
// Multi-channel input debouncer: per-bit two-flop synchronizer, one shared
// sample tick, and a per-channel FSM that needs PULSE_CNT_MAX agreeing ticks.
module debounce_ctrl #(
   parameter int WIDTH          = 1,
   parameter int SAMPLE_CNT_MAX = 25000,
   parameter int PULSE_CNT_MAX  = 200
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] async_in,
   output logic [WIDTH-1:0] level_out,
   output logic [WIDTH-1:0] rise_pulse,
   output logic [WIDTH-1:0] fall_pulse,
   output logic             tick_out
);

   localparam int SW = $clog2(SAMPLE_CNT_MAX);
   localparam int CW = $clog2(PULSE_CNT_MAX + 1);
   localparam logic [SW-1:0] SAMPLE_LAST = SW'(SAMPLE_CNT_MAX - 1);
   localparam logic [CW-1:0] PULSE_LAST  = CW'(PULSE_CNT_MAX - 1);
   localparam logic [CW-1:0] CNT_ONE     = CW'(1);

   typedef enum logic [1:0] {
      ST_LOW       = 2'd0,
      ST_PEND_HIGH = 2'd1,
      ST_HIGH      = 2'd2,
      ST_PEND_LOW  = 2'd3
   } state_t;

   logic [WIDTH-1:0] sync_meta;
   logic [WIDTH-1:0] sync;
   logic [SW-1:0]    sample_cnt;
   logic             tick;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_meta <= '0;
         sync      <= '0;
      end else begin
         sync_meta <= async_in;
         sync      <= sync_meta;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sample_cnt <= '0;
      end else if (sample_cnt == SAMPLE_LAST) begin
         sample_cnt <= '0;
      end else begin
         sample_cnt <= sample_cnt + 1'b1;
      end
   end

   assign tick     = (sample_cnt == SAMPLE_LAST);
   assign tick_out = tick;

   for (genvar i = 0; i < WIDTH; i++) begin : g_ch
      state_t        state_q;
      logic [CW-1:0] cnt_q;
      logic          level_q;
      logic          rise_q;
      logic          fall_q;
      logic          level_next;

      // Output level follows the stable side of the FSM: a pending state
      // still reports the level it is trying to leave.
      assign level_next = (state_q == ST_HIGH) || (state_q == ST_PEND_LOW);

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            state_q <= ST_LOW;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
         end else begin
            if (tick) begin
               case (state_q)
                  ST_LOW: begin
                     if (sync[i]) begin
                        state_q <= ST_PEND_HIGH;
                        cnt_q   <= CNT_ONE;
                     end else begin
                        cnt_q   <= '0;
                     end
                  end
                  ST_PEND_HIGH: begin
                     if (!sync[i]) begin
                        state_q <= ST_LOW;
                        cnt_q   <= '0;
                     end else if (cnt_q == PULSE_LAST) begin
                        state_q <= ST_HIGH;
                        cnt_q   <= '0;
                     end else begin
                        cnt_q   <= cnt_q + 1'b1;
                     end
                  end
                  ST_HIGH: begin
                     if (!sync[i]) begin
                        state_q <= ST_PEND_LOW;
                        cnt_q   <= CNT_ONE;
                     end else begin
                        cnt_q   <= '0;
                     end
                  end
                  ST_PEND_LOW: begin
                     if (sync[i]) begin
                        state_q <= ST_HIGH;
                        cnt_q   <= '0;
                     end else if (cnt_q == PULSE_LAST) begin
                        state_q <= ST_LOW;
                        cnt_q   <= '0;
                     end else begin
                        cnt_q   <= cnt_q + 1'b1;
                     end
                  end
                  default: begin
                     state_q <= ST_LOW;
                     cnt_q   <= '0;
                  end
               endcase
            end
            level_q <= level_next;
            rise_q  <= level_next & ~level_q;
            fall_q  <= ~level_next & level_q;
         end
      end

      assign level_out[i]  = level_q;
      assign rise_pulse[i] = rise_q;
      assign fall_pulse[i] = fall_q;
   end

endmodule

// File: tb/tb_debounce_ctrl.sv
// Bench for debounce_ctrl: directed scenarios plus random bouncing, checked
// against a run-length model of agreeing sample ticks.
module tb_debounce_ctrl;

   localparam int W   = 2;
   localparam int SCM = 4;
   localparam int PCM = 3;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [W-1:0] async_in = '0;
   logic [W-1:0] level_out;
   logic [W-1:0] rise_pulse;
   logic [W-1:0] fall_pulse;
   logic         tick_out;

   debounce_ctrl #(
      .WIDTH         (W),
      .SAMPLE_CNT_MAX(SCM),
      .PULSE_CNT_MAX (PCM)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .async_in  (async_in),
      .level_out (level_out),
      .rise_pulse(rise_pulse),
      .fall_pulse(fall_pulse),
      .tick_out  (tick_out)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: edges since reset, a two-deep delay line of input
   // samples, and per channel the debounced level plus the run length of
   // consecutive ticks that disagreed with it.
   int           edge_n;
   logic [W-1:0] samp_q[$];
   logic [W-1:0] mdl_lvl;
   logic [W-1:0] exp_level;
   logic [W-1:0] exp_rise;
   logic [W-1:0] exp_fall;
   int           run[W];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      edge_n = 0;
      samp_q.delete();
      mdl_lvl   = '0;
      exp_level = '0;
      exp_rise  = '0;
      exp_fall  = '0;
      for (int c = 0; c < W; c++) run[c] = 0;
   endtask

   task automatic step();
      logic [W-1:0] sync_now;
      bit           tick;
      @(posedge clk);
      if (rst_n) begin
         tick     = (edge_n % SCM) == (SCM - 1);
         sync_now = (samp_q.size() == 2) ? samp_q[0] : '0;
         exp_rise  = mdl_lvl & ~exp_level;
         exp_fall  = ~mdl_lvl & exp_level;
         exp_level = mdl_lvl;
         if (tick) begin
            for (int c = 0; c < W; c++) begin
               if (sync_now[c] != mdl_lvl[c]) begin
                  run[c]++;
                  if (run[c] == PCM) begin
                     mdl_lvl[c] = ~mdl_lvl[c];
                     run[c]     = 0;
                  end
               end else begin
                  run[c] = 0;
               end
            end
         end
         samp_q.push_back(async_in);
         if (samp_q.size() > 2) void'(samp_q.pop_front());
         edge_n++;
      end
      @(negedge clk);
      check("level_out", level_out, exp_level);
      check("rise_pulse", rise_pulse, exp_rise);
      check("fall_pulse", fall_pulse, exp_fall);
      check("tick_out", tick_out, (rst_n && (edge_n % SCM) == (SCM - 1)));
      check("rise_fall_exclusive", rise_pulse & fall_pulse, 0);
   endtask

   initial begin
      int rise_at;
      int pulse_at;
      int n_rise;
      int n_fall;
      int n_both;
      int n_partial;
      logic seen;
      int hold[W];

      // Reset held with inputs high: everything stays quiet.
      rst_n    = 1'b0;
      async_in = 2'b11;
      model_reset();
      repeat (5) step();
      check("reset_level", level_out, 0);
      check("reset_tick", tick_out, 0);

      // Single channel rise with latency window and one-cycle pulse.
      rst_n    = 1'b1;
      async_in = 2'b01;
      rise_at  = -1;
      pulse_at = -1;
      n_rise   = 0;
      seen     = 1'b0;
      repeat (20) begin
         step();
         if (level_out[0] && rise_at < 0) rise_at = edge_n - 1;
         if (rise_pulse[0] && pulse_at < 0) pulse_at = edge_n - 1;
         n_rise += int'(rise_pulse[0]);
         seen |= level_out[1] | rise_pulse[1];
      end
      check("rise_latency_window", (rise_at >= 11 && rise_at <= 14), 1);
      check("rise_pulse_coincident", pulse_at, rise_at);
      check("rise_pulse_count", n_rise, 1);
      check("ch1_unaffected", seen, 0);

      // Drop from HIGH, bounce back for 5 cycles, then hold low.
      n_fall = 0;
      n_rise = 0;
      async_in = 2'b00;
      repeat (3) begin step(); n_fall += int'(fall_pulse[0]); n_rise += int'(rise_pulse[0]); end
      async_in = 2'b01;
      repeat (5) begin step(); n_fall += int'(fall_pulse[0]); n_rise += int'(rise_pulse[0]); end
      async_in = 2'b00;
      repeat (30) begin step(); n_fall += int'(fall_pulse[0]); n_rise += int'(rise_pulse[0]); end
      check("bounce_fall_count", n_fall, 1);
      check("bounce_no_rise", n_rise, 0);
      check("bounce_final_level", level_out[0], 0);

      // Short 6-cycle glitch from LOW must be ignored.
      seen = 1'b0;
      async_in = 2'b01;
      repeat (6) begin step(); seen |= level_out[0] | rise_pulse[0]; end
      async_in = 2'b00;
      repeat (25) begin step(); seen |= level_out[0] | rise_pulse[0]; end
      check("glitch_ignored", seen, 0);

      // Both channels rise together.
      n_both    = 0;
      n_partial = 0;
      async_in  = 2'b11;
      repeat (25) begin
         step();
         if (rise_pulse == 2'b11) n_both++;
         if (rise_pulse == 2'b01 || rise_pulse == 2'b10) n_partial++;
      end
      check("dual_rise_count", n_both, 1);
      check("dual_rise_partial", n_partial, 0);
      check("dual_level", level_out, 2'b11);
      async_in = 2'b00;
      repeat (25) step();
      check("dual_fall_level", level_out, 0);

      // Reset in PEND_HIGH with count 2 discards the progress.
      rst_n = 1'b0;
      model_reset();
      step();
      rst_n    = 1'b1;
      async_in = 2'b01;
      repeat (8) step();
      check("pend_level_before_reset", level_out[0], 0);
      rst_n = 1'b0;
      model_reset();
      step();
      check("midreset_level", level_out, 0);
      rst_n   = 1'b1;
      rise_at = -1;
      repeat (20) begin
         step();
         if (level_out[0] && rise_at < 0) rise_at = edge_n - 1;
      end
      check("restart_rise_cycle", rise_at, PCM * SCM);

      // Random bouncing on both channels.
      for (int c = 0; c < W; c++) hold[c] = 0;
      repeat (800) begin
         for (int c = 0; c < W; c++) begin
            if (hold[c] == 0) begin
               async_in[c] = 1'($urandom_range(0, 1));
               hold[c]     = $urandom_range(1, 18);
            end
            hold[c]--;
         end
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/debounce_ctrl.md
DEBOUNCE_CTRL -- requirements
Module: debounce_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 1, giving the number of independent input channels.
REQ-002 The block SHALL have parameter SAMPLE_CNT_MAX, default 25000, giving the clock cycles per sample tick; it must be at least 2.
REQ-003 The block SHALL have parameter PULSE_CNT_MAX, default 200, giving the consecutive agreeing ticks needed to change state; it must be at least 2.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port async_in, input, WIDTH bits: raw asynchronous inputs such as buttons or switches.
REQ-007 The block SHALL have port level_out, output, WIDTH bits: debounced level per channel.
REQ-008 The block SHALL have port rise_pulse, output, WIDTH bits: one-cycle pulse when level_out goes from 0 to 1.
REQ-009 The block SHALL have port fall_pulse, output, WIDTH bits: one-cycle pulse when level_out goes from 1 to 0.
REQ-010 The block SHALL have port tick_out, output, 1 bit: the shared sample-tick strobe, for debug and verification.

Function
REQ-011 Each async_in bit SHALL pass through an internal two-flop synchronizer before any other use; the synchronized bit is called sync[i].
REQ-012 A shared sample counter, $clog2(SAMPLE_CNT_MAX) bits wide, SHALL count from 0 to SAMPLE_CNT_MAX-1 and then wrap to 0.
REQ-013 tick SHALL be combinationally high exactly in the cycle when the sample counter equals SAMPLE_CNT_MAX-1, so it is 1 cycle in every SAMPLE_CNT_MAX.
REQ-014 Each channel SHALL have its own FSM with states LOW, PEND_HIGH, HIGH and PEND_LOW, plus a stability counter $clog2(PULSE_CNT_MAX+1) bits wide.
REQ-015 In LOW with tick=1 and sync=1, the FSM SHALL go to PEND_HIGH and set the counter to 1; otherwise it stays in LOW with the counter at 0.
REQ-016 In PEND_HIGH with tick=1 and sync=1, the counter SHALL increment; when the incremented value equals PULSE_CNT_MAX, the FSM goes to HIGH and clears the counter.
REQ-017 In PEND_HIGH with tick=1 and sync=0, the FSM SHALL return to LOW and clear the counter; with tick=0 it holds state and count.
REQ-018 HIGH and PEND_LOW SHALL mirror REQ-015 to REQ-017 with the polarity of sync inverted.
REQ-019 level_out[i] SHALL be registered: 1 in HIGH and PEND_LOW, 0 in LOW and PEND_HIGH.
REQ-020 rise_pulse[i] SHALL be registered and high for exactly the one cycle in which level_out[i] first reads 1; fall_pulse[i] is the same for the first 0; the two are never both high.
REQ-021 The stability counter SHALL never exceed PULSE_CNT_MAX, and SHALL be cleared on every transition into a stable state.
REQ-022 Channels SHALL be fully independent and SHALL share only the tick; simultaneous transitions on several channels are all allowed.
REQ-023 Latency from an async_in edge to the matching level_out change SHALL be 2 synchronizer cycles, plus 0 to SAMPLE_CNT_MAX-1 cycles waiting for the first tick, plus (PULSE_CNT_MAX-1)*SAMPLE_CNT_MAX cycles, plus 1 output-register cycle.
REQ-024 An input glitch that agrees with the new value on fewer than PULSE_CNT_MAX consecutive ticks SHALL cause no change on level_out and no pulse.

Reset
REQ-025 While rst_n=0, all of the following SHALL be cleared asynchronously: synchronizer flops to 0, sample counter to 0, all FSMs to LOW, all stability counters to 0, and level_out, rise_pulse and fall_pulse to 0.
REQ-026 An assertion of rst_n in the middle of a pending state SHALL discard the pending count; after release the channel restarts from LOW even if async_in is 1.
REQ-027 After rst_n rises, the first tick SHALL occur SAMPLE_CNT_MAX cycles after the first active clock edge.

Verification (bench parameters: WIDTH=2, SAMPLE_CNT_MAX=4, PULSE_CNT_MAX=3)
REQ-028 The bench SHALL hold rst_n=0 with async_in=2'b11 and toggle clk -> all outputs stay 0, and tick_out stays 0.
REQ-029 The bench SHALL raise async_in[0] at cycle 0 and hold it -> level_out[0] rises between cycle 11 and cycle 14, rise_pulse[0] is high for exactly 1 cycle coincident with that rise, and channel 1 is unaffected.
REQ-030 The bench SHALL pulse async_in[0] high for 6 cycles from the LOW state -> level_out[0] and rise_pulse[0] stay 0 throughout.
REQ-031 The bench SHALL drop async_in[0] from the stable HIGH state, bounce it back high for 5 cycles, then hold it low -> exactly one fall_pulse[0], and level_out[0] ends at 0.
REQ-032 The bench SHALL raise both channels in the same cycle -> level_out becomes 2'b11 in the same cycle, and rise_pulse shows 2'b11 for 1 cycle.
REQ-033 The bench SHALL pull rst_n low for 1 cycle while channel 0 is in PEND_HIGH with count 2 -> level_out[0] stays 0, and after release the channel needs 3 new agreeing ticks to rise.
